// File: rtl/cdc_pkg.sv
// Shared definitions for the four-phase handshake CDC transmitter:
// FSM state encoding and default parameter values.
package cdc_pkg;

  localparam int unsigned CDC_BUS_WIDTH_DEF  = 8;
  localparam int unsigned CDC_NUM_STAGES_DEF = 2;

  localparam int unsigned CDC_ST_W = 2;
  typedef logic [CDC_ST_W-1:0] cdc_state_t;

  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_REQ_HI      = 2'd1;
  localparam logic [1:0] ST_ACK_WAIT_LO = 2'd2;

endpackage : cdc_pkg

// File: rtl/cdc_ack_sync.sv
// Multi-flop synchronizer bringing the destination-domain ack into clk.
// NUM_STAGES must be at least 2.
module cdc_ack_sync #(
  parameter int unsigned NUM_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ack_i,
  output logic ack_s_o
);

  logic [NUM_STAGES-1:0] sync_q;
  logic [NUM_STAGES-1:0] sync_d;

  assign sync_d = {sync_q[NUM_STAGES-2:0], ack_i};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign ack_s_o = sync_q[NUM_STAGES-1];

endmodule : cdc_ack_sync

// File: rtl/cdc_hs_tx.sv
// Source side of a four-phase req/ack word transfer across clock domains.
// Optional registered even parity on tx_parity when CDC_TX_PARITY_EN is defined.
module cdc_hs_tx
  import cdc_pkg::*;
#(
  parameter int unsigned BUS_WIDTH  = CDC_BUS_WIDTH_DEF,
  parameter int unsigned NUM_STAGES = CDC_NUM_STAGES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BUS_WIDTH-1:0] tx_data,
  output logic                 tx_req,
  input  logic                 tx_ack,
  output logic                 busy,
  output logic                 done
`ifdef CDC_TX_PARITY_EN
  ,
  output logic                 tx_parity
`endif
);

  logic                 ack_s;
  logic                 accept;
  cdc_state_t           state_q,   state_d;
  logic                 tx_req_q,  tx_req_d;
  logic [BUS_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                 done_q,    done_d;
  logic                 busy_q,    busy_d;

  cdc_ack_sync #(
    .NUM_STAGES(NUM_STAGES)
  ) u_ack_sync (
    .clk    (clk),
    .rst    (rst),
    .ack_i  (tx_ack),
    .ack_s_o(ack_s)
  );

  // A late ack still high in IDLE holds off the next transfer.
  assign in_ready = (state_q == cdc_state_t'(ST_IDLE)) && !ack_s;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    tx_req_d  = tx_req_q;
    tx_data_d = tx_data_q;
    done_d    = 1'b0;
    case (state_q)
      cdc_state_t'(ST_IDLE): begin
        if (accept) begin
          tx_data_d = in_data;
          tx_req_d  = 1'b1;
          state_d   = cdc_state_t'(ST_REQ_HI);
        end
      end
      cdc_state_t'(ST_REQ_HI): begin
        if (ack_s) begin
          tx_req_d = 1'b0;
          state_d  = cdc_state_t'(ST_ACK_WAIT_LO);
        end
      end
      cdc_state_t'(ST_ACK_WAIT_LO): begin
        if (!ack_s) begin
          done_d  = 1'b1;
          state_d = cdc_state_t'(ST_IDLE);
        end
      end
      default: begin
        tx_req_d = 1'b0;
        state_d  = cdc_state_t'(ST_IDLE);
      end
    endcase
    busy_d = (state_d != cdc_state_t'(ST_IDLE));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= cdc_state_t'(ST_IDLE);
      tx_req_q  <= 1'b0;
      tx_data_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_req_q  <= tx_req_d;
      tx_data_q <= tx_data_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign tx_data = tx_data_q;
  assign tx_req  = tx_req_q;
  assign done    = done_q;
  assign busy    = busy_q;

`ifdef CDC_TX_PARITY_EN
  logic parity_q, parity_d;

  // Parity is captured alongside tx_data and held with it.
  assign parity_d = accept ? (^in_data) : parity_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign tx_parity = parity_q;
`endif

endmodule : cdc_hs_tx

// File: tb/tb_cdc_hs_tx.sv
// Directed self-checking bench for cdc_hs_tx (NUM_STAGES=2, BUS_WIDTH=8).
// Parity checks are included when CDC_TX_PARITY_EN is defined.
module tb_cdc_hs_tx;

  localparam int unsigned BW = 8;
  localparam int unsigned NS = 2;

  logic          clk;
  logic          rst;
  logic [BW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] tx_data;
  logic          tx_req;
  logic          tx_ack;
  logic          busy;
  logic          done;
`ifdef CDC_TX_PARITY_EN
  logic          tx_parity;
`endif

  int n_cmp = 0;
  int n_err = 0;

  cdc_hs_tx #(
    .BUS_WIDTH (BW),
    .NUM_STAGES(NS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .tx_ack   (tx_ack),
    .busy     (busy),
    .done     (done)
`ifdef CDC_TX_PARITY_EN
    ,
    .tx_parity(tx_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ack high for 3 cycles then low for 3; leaves the bench just after the done edge.
  task automatic run_ack();
    tx_ack = 1'b1;
    repeat (3) tick();
    tx_ack = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_data = '0; tx_ack = 1'b0;
    #2;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready_during: got %b want 1", in_ready); end
    tick();
    rst = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (tx_req !== 1'b0) begin n_err++; $display("FAIL rst_tx_req: got %b want 0", tx_req); end
    n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
`ifdef CDC_TX_PARITY_EN
    n_cmp++; if (tx_parity !== 1'b0) begin n_err++; $display("FAIL rst_parity: got %b want 0", tx_parity); end
`endif
  endtask

  task automatic test_single();
    in_data = 8'hA5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_data = 8'h00;
    n_cmp++; if (tx_req !== 1'b1) begin n_err++; $display("FAIL single_req_set: got %b want 1", tx_req); end
    n_cmp++; if (tx_data !== 8'hA5) begin n_err++; $display("FAIL single_capture: got %h want a5", tx_data); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", busy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL single_ready_low: got %b want 0", in_ready); end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (tx_req !== 1'b1) begin n_err++; $display("FAIL single_req_hold[%0d]: got %b want 1", i, tx_req); end
    end
    tx_ack = 1'b1;
    // Two edges fill the synchronizer; tx_req drops on the third.
    tick(); tick();
    n_cmp++; if (tx_req !== 1'b1) begin n_err++; $display("FAIL single_req_before_sync: got %b want 1", tx_req); end
    tick();
    n_cmp++; if (tx_req !== 1'b0) begin n_err++; $display("FAIL single_req_fall: got %b want 0", tx_req); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_wait_lo: got %b want 1", busy); end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL single_done_early[%0d]: got %b want 0", i, done); end
      n_cmp++; if (tx_data !== 8'hA5) begin n_err++; $display("FAIL single_data_hold[%0d]: got %h want a5", i, tx_data); end
    end
    tx_ack = 1'b0;
    tick(); tick();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL single_done_before_sync: got %b want 0", done); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_before_done: got %b want 1", busy); end
    tick();
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL single_done_pulse: got %b want 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_clear: got %b want 0", busy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL single_ready_back: got %b want 1", in_ready); end
    n_cmp++; if (tx_data !== 8'hA5) begin n_err++; $display("FAIL single_data_at_done: got %h want a5", tx_data); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL single_done_one_cycle: got %b want 0", done); end
  endtask

  task automatic test_busy_ignore();
    in_data = 8'hA5; in_valid = 1'b1;
    tick();
    in_data = 8'h3C;
    tick();
    n_cmp++; if (tx_data !== 8'hA5) begin n_err++; $display("FAIL busy_no_resample: got %h want a5", tx_data); end
    run_ack();
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL busy_done: got %b want 1", done); end
    n_cmp++; if (tx_data !== 8'hA5) begin n_err++; $display("FAIL busy_data_until_idle: got %h want a5", tx_data); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL busy_ready_after_done: got %b want 1", in_ready); end
    tick();
    n_cmp++; if (tx_data !== 8'h3C) begin n_err++; $display("FAIL b2b_capture: got %h want 3c", tx_data); end
    n_cmp++; if (tx_req !== 1'b1) begin n_err++; $display("FAIL b2b_req: got %b want 1", tx_req); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL b2b_done_clear: got %b want 0", done); end
    in_valid = 1'b0;
    run_ack();
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got %b want 0", busy); end
  endtask

  task automatic test_spurious_ack();
    tx_ack = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      n_cmp++; if (in_ready !== (i >= 2 ? 1'b0 : 1'b1)) begin n_err++; $display("FAIL spur_ready[%0d]: got %b want %b", i, in_ready, (i >= 2 ? 1'b0 : 1'b1)); end
      n_cmp++; if (tx_req !== 1'b0) begin n_err++; $display("FAIL spur_req[%0d]: got %b want 0", i, tx_req); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL spur_busy[%0d]: got %b want 0", i, busy); end
      if (i == 2) begin
        in_data = 8'h55; in_valid = 1'b1;
      end
    end
    tx_ack = 1'b0;
    tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL spur_ready_sync1: got %b want 0", in_ready); end
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL spur_ready_sync2: got %b want 1", in_ready); end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (tx_data !== 8'h3C) begin n_err++; $display("FAIL spur_no_accept: got %h want 3c", tx_data); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL spur_idle: got %b want 0", busy); end
  endtask

  task automatic test_reset_abort();
    in_data = 8'h5A; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (tx_req !== 1'b1) begin n_err++; $display("FAIL abort_req_before: got %b want 1", tx_req); end
    tx_ack = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (tx_req !== 1'b0) begin n_err++; $display("FAIL abort_req: got %b want 0", tx_req); end
    n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL abort_data: got %h want 00", tx_data); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL abort_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_done_in_rst[%0d]: got %b want 0", i, done); end
    end
    rst = 1'b1;
    tick(); tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL abort_ack_blocks: got %b want 0", in_ready); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_no_done: got %b want 0", done); end
    tx_ack = 1'b0;
    tick(); tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL abort_ready_after: got %b want 1", in_ready); end
  endtask

`ifdef CDC_TX_PARITY_EN
  task automatic test_parity();
    in_data = 8'h07; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_data = 8'h00;
    n_cmp++; if (tx_parity !== 1'b1) begin n_err++; $display("FAIL parity_07: got %b want 1", tx_parity); end
    run_ack();
    tick();
    n_cmp++; if (tx_parity !== 1'b1) begin n_err++; $display("FAIL parity_hold: got %b want 1", tx_parity); end
    in_data = 8'h03; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (tx_parity !== 1'b0) begin n_err++; $display("FAIL parity_03: got %b want 0", tx_parity); end
    run_ack();
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_busy_ignore();
    test_spurious_ack();
    test_reset_abort();
`ifdef CDC_TX_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_cdc_hs_tx
